// File: rtl/median_filter_3x3_stream.sv
// Streaming 3x3 median filter: two line buffers, 3x3 window, pipelined median network, valid/ready flow control.
// Optional MEDIAN_BYPASS_EN adds bypassEn, which forwards the window centre instead of the median.
module median_filter_3x3_stream #(
    parameter int unsigned DATA_SIZE  = 8,
    parameter int unsigned LINE_WIDTH = 640,
    parameter int unsigned ADDR_SIZE  = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] pixIn,
    input  logic                 pixInValid,
    input  logic                 frameStart,
`ifdef MEDIAN_BYPASS_EN
    input  logic                 bypassEn,
`endif
    output logic                 pixInReady,
    output logic [DATA_SIZE-1:0] pixOut,
    output logic                 pixOutValid,
    input  logic                 pixOutReady
);

    localparam int unsigned LAST_COL = LINE_WIDTH - 1;

    typedef logic [DATA_SIZE-1:0] pixelT;

    function automatic pixelT minOf(input pixelT a, input pixelT b);
        return (a < b) ? a : b;
    endfunction

    function automatic pixelT maxOf(input pixelT a, input pixelT b);
        return (a > b) ? a : b;
    endfunction

    function automatic pixelT med3(input pixelT a, input pixelT b, input pixelT c);
        return maxOf(minOf(a, b), minOf(maxOf(a, b), c));
    endfunction

    logic                 adv;
    logic                 accept;
    logic                 lastCol;
    logic [ADDR_SIZE-1:0] colCnt;
    logic [ADDR_SIZE-1:0] curCol;
    logic [1:0]           rowCnt;
    logic [1:0]           curRow;

    // Whole pipeline advances together; output register full and blocked freezes everything.
    assign adv        = ~pixOutValid | pixOutReady;
    assign pixInReady = adv;
    assign accept     = pixInValid & adv & ~rst;
    assign curCol     = frameStart ? '0 : colCnt;
    assign curRow     = frameStart ? 2'd0 : rowCnt;
    assign lastCol    = (curCol == ADDR_SIZE'(LAST_COL));

    always_ff @(posedge clk) begin
        if (rst) begin
            colCnt <= '0;
            rowCnt <= 2'd0;
        end else if (accept) begin
            if (lastCol) begin
                colCnt <= '0;
                rowCnt <= (curRow == 2'd2) ? 2'd2 : curRow + 2'd1;
            end else begin
                colCnt <= curCol + ADDR_SIZE'(1);
                rowCnt <= curRow;
            end
        end
    end

    pixelT lineBuf0 [LINE_WIDTH];
    pixelT lineBuf1 [LINE_WIDTH];
    pixelT s0Top;
    pixelT s0Mid;
    pixelT s0Pix;
    logic  s0Acc;
    logic  s0Win;

    // Line buffers with registered read: s0 holds the column {row-2, row-1, row} of the accepted pixel.
    always_ff @(posedge clk) begin
        if (accept) begin
            lineBuf1[curCol] <= pixIn;
            lineBuf0[curCol] <= lineBuf1[curCol];
            s0Top            <= lineBuf0[curCol];
            s0Mid            <= lineBuf1[curCol];
            s0Pix            <= pixIn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0Acc <= 1'b0;
            s0Win <= 1'b0;
        end else if (adv) begin
            s0Acc <= accept;
            s0Win <= accept & (curRow == 2'd2) & (curCol >= ADDR_SIZE'(2));
        end
    end

    pixelT win [3][3];
    logic  s1Valid;

    // Window shifts only for accepted pixels so bubbles leave it intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (adv) begin
            s1Valid <= s0Acc & s0Win;
            if (s0Acc) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= s0Top;
                win[1][2] <= s0Mid;
                win[2][2] <= s0Pix;
            end
        end
    end

    pixelT rowLo  [3];
    pixelT rowMid [3];
    pixelT rowHi  [3];
    logic  s2Valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2Valid <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                rowLo[r]  <= '0;
                rowMid[r] <= '0;
                rowHi[r]  <= '0;
            end
        end else if (adv) begin
            s2Valid <= s1Valid;
            for (int r = 0; r < 3; r++) begin
                rowLo[r]  <= minOf(minOf(win[r][0], win[r][1]), win[r][2]);
                rowMid[r] <= med3(win[r][0], win[r][1], win[r][2]);
                rowHi[r]  <= maxOf(maxOf(win[r][0], win[r][1]), win[r][2]);
            end
        end
    end

    pixelT maxLo;
    pixelT medMid;
    pixelT minHi;
    logic  s3Valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s3Valid <= 1'b0;
            maxLo   <= '0;
            medMid  <= '0;
            minHi   <= '0;
        end else if (adv) begin
            s3Valid <= s2Valid;
            maxLo   <= maxOf(maxOf(rowLo[0], rowLo[1]), rowLo[2]);
            medMid  <= med3(rowMid[0], rowMid[1], rowMid[2]);
            minHi   <= minOf(minOf(rowHi[0], rowHi[1]), rowHi[2]);
        end
    end

`ifdef MEDIAN_BYPASS_EN
    logic  s0Byp;
    logic  s1Byp;
    logic  s2Byp;
    logic  s3Byp;
    pixelT s2Center;
    pixelT s3Center;

    // Bypass flag travels with its pixel; centre pixel is tapped from the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0Byp    <= 1'b0;
            s1Byp    <= 1'b0;
            s2Byp    <= 1'b0;
            s3Byp    <= 1'b0;
            s2Center <= '0;
            s3Center <= '0;
        end else if (adv) begin
            if (accept) begin
                s0Byp <= bypassEn;
            end
            if (s0Acc) begin
                s1Byp <= s0Byp;
            end
            s2Byp    <= s1Byp;
            s3Byp    <= s2Byp;
            s2Center <= win[1][1];
            s3Center <= s2Center;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pixOutValid <= 1'b0;
            pixOut      <= '0;
        end else if (adv) begin
            pixOutValid <= s3Valid;
            if (s3Valid) begin
`ifdef MEDIAN_BYPASS_EN
                pixOut <= s3Byp ? s3Center : med3(maxLo, medMid, minHi);
`else
                pixOut <= med3(maxLo, medMid, minHi);
`endif
            end
        end
    end

endmodule

// File: tb/tb_median_filter_3x3_stream.sv
// Bench for median_filter_3x3_stream: random and directed frames checked against a sort-based 3x3 median model.
module tb_median_filter_3x3_stream;

    localparam int unsigned DW = 8;
    localparam int unsigned LW = 4;
    localparam int unsigned AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] pixIn = '0;
    logic          pixInValid = 1'b0;
    logic          frameStart = 1'b0;
    logic          pixInReady;
    logic [DW-1:0] pixOut;
    logic          pixOutValid;
    logic          pixOutReady = 1'b1;
`ifdef MEDIAN_BYPASS_EN
    logic          bypassEn = 1'b0;
`endif

    median_filter_3x3_stream #(
        .DATA_SIZE (DW),
        .LINE_WIDTH(LW),
        .ADDR_SIZE (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pixIn      (pixIn),
        .pixInValid (pixInValid),
        .frameStart (frameStart),
`ifdef MEDIAN_BYPASS_EN
        .bypassEn   (bypassEn),
`endif
        .pixInReady (pixInReady),
        .pixOut     (pixOut),
        .pixOutValid(pixOutValid),
        .pixOutReady(pixOutReady)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int passes = 0;
    int firstOutCyc = -1;
    int acc10 = -1;
    int lastAcc = 0;
    logic [7:0] gotQ[$];
    logic [7:0] expQ[$];
    logic [7:0] frame [8][4];

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: a beat transfers at the next rising edge when valid and ready are both high.
    always @(negedge clk) begin
        if (pixOutValid && firstOutCyc < 0) firstOutCyc = cyc;
        if (pixOutValid && pixOutReady) gotQ.push_back(pixOut);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    endtask

    // Reference: true median (or centre) of every interior 3x3 neighbourhood, raster order.
    task automatic buildExpected(input int h, input bit byp);
        expQ.delete();
        for (int r = 1; r < h - 1; r++) begin
            for (int c = 1; c < int'(LW) - 1; c++) begin
                int unsigned vals[$];
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        vals.push_back(int'(frame[r+dr][c+dc]));
                vals.sort();
                expQ.push_back(byp ? frame[r][c] : 8'(vals[4]));
            end
        end
    endtask

    task automatic checkFrame(input string tag);
        check({tag, "_count"}, 32'(gotQ.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
            check($sformatf("%s_out%0d", tag, i), 32'(gotQ[i]), 32'(expQ[i]));
    endtask

    task automatic randFrame(input int h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < int'(LW); c++)
                frame[r][c] = 8'($urandom);
    endtask

    task automatic sendPix(input logic [7:0] p, input bit fs, input bit randStall);
        bit done = 1'b0;
        pixIn = p;
        pixInValid = 1'b1;
        frameStart = fs;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (pixInReady) begin
                lastAcc = cyc + 1;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!done && randStall) pixOutReady = 1'($urandom_range(0, 1));
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
        pixInValid = 1'b0;
        frameStart = 1'b0;
        if (randStall) pixOutReady = ($urandom_range(0, 2) != 0);
    endtask

    task automatic sendFrame(input int h, input bit randStall, input bit bubbles);
        acc10 = -1;
        if (!randStall) pixOutReady = 1'b1;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < int'(LW); c++) begin
                sendPix(frame[r][c], (r == 0 && c == 0), randStall);
                if (r * int'(LW) + c == 10) acc10 = lastAcc;
                if (bubbles && $urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic drain();
        pixOutReady = 1'b1;
        repeat (12) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] held;
        bit seen;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_valid", 32'(pixOutValid), 32'd0);
        check("reset_pixout", 32'(pixOut), 32'd0);
        check("reset_ready", 32'(pixInReady), 32'd1);
        @(posedge clk);
        #1;

        // Flat frame and first-output latency
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < int'(LW); c++)
                frame[r][c] = 8'h40;
        gotQ.delete();
        firstOutCyc = -1;
        sendFrame(4, 1'b0, 1'b0);
        drain();
        buildExpected(4, 1'b0);
        checkFrame("flat");
        for (int i = 0; i < gotQ.size(); i++) check($sformatf("flat_const%0d", i), 32'(gotQ[i]), 32'h40);
        check("flat_latency", 32'(firstOutCyc), 32'(acc10 + 4));

        // Impulse removal
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < int'(LW); c++)
                frame[r][c] = 8'h00;
        frame[1][1] = 8'hFF;
        gotQ.delete();
        sendFrame(4, 1'b0, 1'b0);
        drain();
        buildExpected(4, 1'b0);
        checkFrame("impulse");
        check("impulse_first", (gotQ.size() > 0) ? 32'(gotQ[0]) : 32'hDEAD, 32'h00);

        // Ranked window {9,1,5},{3,7,2},{8,4,6}
        randFrame(4);
        frame[0][0] = 8'd9; frame[0][1] = 8'd1; frame[0][2] = 8'd5;
        frame[1][0] = 8'd3; frame[1][1] = 8'd7; frame[1][2] = 8'd2;
        frame[2][0] = 8'd8; frame[2][1] = 8'd4; frame[2][2] = 8'd6;
        gotQ.delete();
        sendFrame(4, 1'b0, 1'b0);
        drain();
        buildExpected(4, 1'b0);
        checkFrame("ranked");
        check("ranked_first", (gotQ.size() > 0) ? 32'(gotQ[0]) : 32'hDEAD, 32'd5);

        // Directed 3-cycle back-pressure with a pending input pixel
        randFrame(4);
        gotQ.delete();
        pixOutReady = 1'b1;
        for (int i = 0; i < 12; i++) sendPix(frame[i / 4][i % 4], (i == 0), 1'b0);
        pixOutReady = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            seen = pixOutValid;
        end
        check("stall_seen", 32'(seen), 32'd1);
        held = pixOut;
        pixIn = frame[3][0];
        pixInValid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("stall_valid", 32'(pixOutValid), 32'd1);
            check("stall_hold", 32'(pixOut), 32'(held));
            check("stall_inready", 32'(pixInReady), 32'd0);
        end
        @(posedge clk);
        #1;
        pixOutReady = 1'b1;
        for (int i = 12; i < 16; i++) sendPix(frame[i / 4][i % 4], 1'b0, 1'b0);
        drain();
        buildExpected(4, 1'b0);
        checkFrame("stall");

        // Random back-pressure and bubbles on a taller frame
        randFrame(6);
        gotQ.delete();
        sendFrame(6, 1'b1, 1'b1);
        drain();
        buildExpected(6, 1'b0);
        checkFrame("random");

        // Reset mid-frame with a pixel in flight, then a fresh frame
        randFrame(4);
        gotQ.delete();
        for (int i = 0; i < 11; i++) sendPix(frame[i / 4][i % 4], (i == 0), 1'b0);
        pixIn = 8'hAA;
        pixInValid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pixInValid = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(pixOutValid), 32'd0);
        check("rst_pixout", 32'(pixOut), 32'd0);
        check("rst_inready", 32'(pixInReady), 32'd1);
        repeat (8) @(posedge clk);
        #1;
        check("rst_no_output", 32'(gotQ.size()), 32'd0);
        randFrame(4);
        gotQ.delete();
        firstOutCyc = -1;
        sendFrame(4, 1'b0, 1'b0);
        drain();
        buildExpected(4, 1'b0);
        checkFrame("after_rst");
        check("after_rst_latency", 32'(firstOutCyc), 32'(acc10 + 4));

        // frameStart arriving mid-line
        gotQ.delete();
        sendPix(8'h11, 1'b0, 1'b0);
        sendPix(8'h22, 1'b0, 1'b0);
        randFrame(5);
        sendFrame(5, 1'b0, 1'b1);
        drain();
        buildExpected(5, 1'b0);
        checkFrame("midline");

`ifdef MEDIAN_BYPASS_EN
        // Bypass forwards the centre pixel at unchanged latency
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < int'(LW); c++)
                frame[r][c] = 8'h00;
        frame[1][1] = 8'hFF;
        bypassEn = 1'b1;
        gotQ.delete();
        firstOutCyc = -1;
        sendFrame(4, 1'b0, 1'b0);
        drain();
        bypassEn = 1'b0;
        buildExpected(4, 1'b1);
        checkFrame("bypass");
        check("bypass_first", (gotQ.size() > 0) ? 32'(gotQ[0]) : 32'hDEAD, 32'hFF);
        check("bypass_latency", 32'(firstOutCyc), 32'(acc10 + 4));
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
